// File: rtl/intc_vec.sv
// Vectored interrupt requester: edge-captures four done lines and serves them by priority.
// Optional per-source masking via INTC_MASK_EN (adds the int_mask port).
module intc_vec #(
   parameter logic [31:0] VEC_BASE  = 32'h0000_0100,
   parameter int unsigned VEC_SHIFT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        done1,
   input  logic        done2,
   input  logic        done3,
   input  logic        done4,
   input  logic        int_ack,
`ifdef INTC_MASK_EN
   input  logic [3:0]  int_mask,
`endif
   output logic        interrupt,
   output logic [31:0] int_addr,
   output logic [1:0]  int_id,
   output logic [3:0]  pending,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  done_q;
   logic [3:0]  pend_q, pend_d;
   logic [1:0]  id_q, id_d;
   logic [31:0] addr_q, addr_d;
   logic        irq_q, irq_d;

   logic [3:0]  done_v;
   logic [3:0]  rise;
   logic [3:0]  mask;
   logic [3:0]  elig;
   logic [3:0]  clr;
   logic [1:0]  pick;

   assign done_v = {done4, done3, done2, done1};
   assign rise   = done_v & ~done_q;

`ifdef INTC_MASK_EN
   assign mask = int_mask;
`else
   assign mask = 4'b1111;
`endif

   assign elig = pend_q & mask;

   // Lowest index wins: scan from the bottom priority upward.
   always_comb begin
      pick = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (elig[i]) pick = 2'(i);
      end
   end

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      addr_d  = addr_q;
      irq_d   = irq_q;
      clr     = 4'b0000;
      unique case (state_q)
         IDLE: begin
            if (|elig) begin
               state_d = REQ;
               id_d    = pick;
               addr_d  = VEC_BASE + (32'(pick) << VEC_SHIFT);
               irq_d   = 1'b1;
            end
         end
         REQ: begin
            if (int_ack) begin
               state_d = GAP;
               clr     = 4'b0001 << id_q;
               addr_d  = 32'h0;
               irq_d   = 1'b0;
            end
         end
         GAP: begin
            if (!int_ack) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            addr_d  = 32'h0;
            irq_d   = 1'b0;
         end
      endcase
   end

   // A rise in the same cycle as its ack-clear keeps the bit set.
   assign pend_d = (pend_q & ~clr) | rise;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         done_q  <= 4'b1111;
         pend_q  <= 4'b0000;
         id_q    <= 2'd0;
         addr_q  <= 32'h0;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_v;
         pend_q  <= pend_d;
         id_q    <= id_d;
         addr_q  <= addr_d;
         irq_q   <= irq_d;
      end
   end

   assign interrupt = irq_q;
   assign int_addr  = addr_q;
   assign int_id    = (state_q == IDLE) ? 2'b00 : id_q;
   assign pending   = pend_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_intc_vec.sv
// Scoreboard bench for intc_vec: expected vectors queued at stimulus, checked on request.
// Mask scenario runs only when INTC_MASK_EN is defined.
module tb_intc_vec;

   logic        clk = 1'b0;
   logic        reset;
   logic        done1, done2, done3, done4;
   logic        int_ack;
`ifdef INTC_MASK_EN
   logic [3:0]  int_mask;
`endif
   logic        interrupt;
   logic [31:0] int_addr;
   logic [1:0]  int_id;
   logic [3:0]  pending;
   logic        busy;

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  id;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_bad = 0;

   intc_vec #(
      .VEC_BASE (32'h0000_0100),
      .VEC_SHIFT(4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .done1    (done1),
      .done2    (done2),
      .done3    (done3),
      .done4    (done4),
      .int_ack  (int_ack),
`ifdef INTC_MASK_EN
      .int_mask (int_mask),
`endif
      .interrupt(interrupt),
      .int_addr (int_addr),
      .int_id   (int_id),
      .pending  (pending),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] a, input logic [1:0] id);
      exp_t e;
      e.addr = a;
      e.id   = id;
      sb.push_back(e);
   endtask

   task automatic expect_req(input string tag);
      exp_t e;
      check({tag, "_sb"}, 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, "_irq"}, 32'(interrupt), 32'd1);
         check({tag, "_addr"}, int_addr, e.addr);
         check({tag, "_id"}, 32'(int_id), 32'(e.id));
      end
   endtask

   task automatic ack_pulse();
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      tick();
   endtask

   initial begin
      logic seen;
      reset   = 1'b0;
      int_ack = 1'b0;
      {done4, done3, done2, done1} = 4'b1111;
`ifdef INTC_MASK_EN
      int_mask = 4'b1111;
`endif
      repeat (3) tick();
      check("rst_irq", 32'(interrupt), 0);
      check("rst_addr", int_addr, 0);
      check("rst_id", 32'(int_id), 0);
      check("rst_pend", 32'(pending), 0);
      check("rst_busy", 32'(busy), 0);

      // Lines already high at release must not count as events.
      reset = 1'b1;
      seen  = 1'b0;
      repeat (10) begin
         tick();
         seen |= interrupt | busy | (|pending) | (|int_addr);
      end
      check("quiet10", 32'(seen), 0);

      {done4, done3, done2, done1} = 4'b0000;
      tick();
      check("fall_nop", 32'(pending), 0);

      // Single source, 2-cycle latency.
      done3 = 1'b1;
      push(32'h120, 2'd2);
      tick();
      check("d3_pend", 32'(pending), 32'b0100);
      check("d3_early", 32'(interrupt), 0);
      tick();
      expect_req("d3");
      int_ack = 1'b1;
      tick();
      check("d3_ack_irq", 32'(interrupt), 0);
      check("d3_ack_pend", 32'(pending), 0);
      check("gap_busy", 32'(busy), 1);
      check("gap_id", 32'(int_id), 2);
      check("gap_addr", int_addr, 0);
      int_ack = 1'b0;
      tick();
      check("idle_busy", 32'(busy), 0);
      check("idle_id", 32'(int_id), 0);
      done3 = 1'b0;

      // Simultaneous done1/done4, back-to-back service.
      done1 = 1'b1;
      done4 = 1'b1;
      push(32'h100, 2'd0);
      push(32'h130, 2'd3);
      tick();
      check("d14_pend", 32'(pending), 32'b1001);
      tick();
      expect_req("d14_a");
      int_ack = 1'b1;
      tick();
      check("d14_pend2", 32'(pending), 32'b1000);
      int_ack = 1'b0;
      tick();
      check("d14_gapdone", 32'(interrupt), 0);
      tick();
      expect_req("d14_b");

      // done2 and done4 rise during REQ; done4 coincides with ack.
      done1 = 1'b0;
      done4 = 1'b0;
      tick();
      done2 = 1'b1;
      tick();
      check("hold_addr", int_addr, 32'h130);
      check("hold_id", 32'(int_id), 3);
      check("hold_pend", 32'(pending), 32'b1010);
      done4   = 1'b1;
      int_ack = 1'b1;
      push(32'h110, 2'd1);
      push(32'h130, 2'd3);
      tick();
      check("setwin_pend", 32'(pending), 32'b1010);
      check("setwin_irq", 32'(interrupt), 0);
      int_ack = 1'b0;
      tick();
      tick();
      expect_req("next_d2");
      ack_pulse();
      tick();
      expect_req("third_d4");
      ack_pulse();
      check("drain_pend", 32'(pending), 0);
      {done4, done3, done2, done1} = 4'b0000;
      tick();

      // Held-high line must not retrigger; ack in IDLE is ignored.
      int_ack = 1'b1;
      repeat (3) tick();
      check("ack_idle_busy", 32'(busy), 0);
      int_ack = 1'b0;

      // Reset in REQ drops the request.
      done1 = 1'b1;
      push(32'h100, 2'd0);
      tick();
      tick();
      expect_req("pre_rst");
      reset = 1'b0;
      tick();
      check("rst_req_irq", 32'(interrupt), 0);
      check("rst_req_pend", 32'(pending), 0);
      check("rst_req_busy", 32'(busy), 0);
      reset = 1'b1;
      seen  = 1'b0;
      repeat (5) begin
         tick();
         seen |= interrupt | (|pending);
      end
      check("no_replay", 32'(seen), 0);
      done1 = 1'b0;
      tick();

`ifdef INTC_MASK_EN
      int_mask = 4'b1110;
      done1    = 1'b1;
      tick();
      check("msk_pend", 32'(pending), 32'b0001);
      tick();
      tick();
      check("msk_irq", 32'(interrupt), 0);
      int_mask = 4'b1111;
      push(32'h100, 2'd0);
      tick();
      expect_req("unmask");
      ack_pulse();
      done1 = 1'b0;
      tick();
`endif

      check("sb_empty", 32'(sb.size()), 0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
